// File: rtl/operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : operand_feeder
// Summary  : N-lane FWFT operand FIFOs feeding one edge of the systolic array.
//            Filled by the host, streamed to the array, pulses finished when
//            every lane has drained.
// Revision : 1.0
// ============================================================================
module operand_feeder #(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 3,
   parameter int DEPTH      = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wr_valid,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_lane,
   input  logic [DATA_WIDTH-1:0]                wr_data,
   output logic                                 wr_ready,
   input  logic                                 commit,
   input  logic [N-1:0]                         rd_en,
   output logic [N*DATA_WIDTH-1:0]              rd_data,
   output logic [N-1:0]                         lane_empty,
   output logic                                 busy,
   output logic                                 finished,
   output logic [1:0]                           err
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [LW:0]   c_N_EXT = (LW + 1)'(N);
   localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [N-1:0] w_full;
   logic [N-1:0] w_push;
   logic [N-1:0] w_pop;
   logic [N-1:0] w_underflow;
   logic [N-1:0] w_cnt_nxt_zero;
   logic         w_lane_ok;
   logic         w_sel_full;
   logic         w_wr_fire;
   logic [1:0]   r_err;

   assign w_lane_ok = ({1'b0, wr_lane} < c_N_EXT);

   always_comb begin
      w_sel_full = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (wr_lane == LW'(k)) begin
            w_sel_full = w_full[k];
         end
      end
   end

   // Out-of-range lanes are always accepted so the host never stalls on them.
   assign wr_ready  = (r_state == ST_FILL) && (!w_lane_ok || !w_sel_full);
   assign w_wr_fire = wr_valid && wr_ready;

   generate
      for (genvar k = 0; k < N; k++) begin : g_lane
         logic [DATA_WIDTH-1:0] r_mem [DEPTH];
         logic [PW-1:0]         r_wptr;
         logic [PW-1:0]         r_rptr;
         logic [CW-1:0]         r_cnt;

         assign w_full[k]         = (r_cnt == c_DEPTH);
         assign w_push[k]         = w_wr_fire && w_lane_ok && (wr_lane == LW'(k));
         assign w_pop[k]          = (r_state == ST_STREAM) && rd_en[k] && (r_cnt != '0);
         assign w_underflow[k]    = (r_state == ST_STREAM) && rd_en[k] && (r_cnt == '0);
         assign w_cnt_nxt_zero[k] = (r_cnt == '0) || (w_pop[k] && (r_cnt == CW'(1)));
         assign lane_empty[k]     = (r_cnt == '0);
         assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
            lane_empty[k] ? '0 : r_mem[r_rptr];

         always_ff @(posedge clk) begin
            if (w_push[k]) begin
               r_mem[r_wptr] <= wr_data;
            end
         end

         // Pushes happen only in FILL and pops only in STREAM, so they never collide.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_wptr <= '0;
               r_rptr <= '0;
               r_cnt  <= '0;
            end else if (w_push[k]) begin
               r_wptr <= r_wptr + PW'(1);
               r_cnt  <= r_cnt + CW'(1);
            end else if (w_pop[k]) begin
               r_rptr <= r_rptr + PW'(1);
               r_cnt  <= r_cnt - CW'(1);
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FILL;
         r_err   <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         if (|w_underflow) begin
            r_err[0] <= 1'b1;
         end
         if (w_wr_fire && !w_lane_ok) begin
            r_err[1] <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FILL:   if (commit) w_state_nxt = ST_STREAM;
         ST_STREAM: if (&w_cnt_nxt_zero) w_state_nxt = ST_DONE;
         ST_DONE:   w_state_nxt = ST_FILL;
         default:   w_state_nxt = ST_FILL;
      endcase
   end

   assign busy     = (r_state != ST_FILL);
   assign finished = (r_state == ST_DONE);
   assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_feeder
// Summary  : Directed and random checks of operand_feeder against a queue model.
// Revision : 1.0
// ============================================================================
module tb_operand_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic [1:0]  wr_lane;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        commit;
   logic [2:0]  rd_en;
   logic [95:0] rd_data;
   logic [2:0]  lane_empty;
   logic        busy;
   logic        finished;
   logic [1:0]  err;

   int total = 0;
   int bad   = 0;

   // Reference model: one queue per lane plus a coarse phase (0 fill, 1 stream, 2 done).
   int unsigned q [3][$];
   int          mphase;
   logic [1:0]  merr;

   operand_feeder #(.DATA_WIDTH(32), .N(3), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_lane    (wr_lane),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .commit     (commit),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .lane_empty (lane_empty),
      .busy       (busy),
      .finished   (finished),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
   task automatic cyc(input logic r, input logic wv, input logic [1:0] wl,
                      input logic [31:0] wd, input logic cm, input logic [2:0] re,
                      input bit do_chk = 1'b1);
      logic [95:0] exp_data;
      logic [2:0]  exp_empty;
      logic        exp_ready;
      bit          all_empty;
      rst = r; wr_valid = wv; wr_lane = wl; wr_data = wd; commit = cm; rd_en = re;
      @(negedge clk);
      exp_data  = '0;
      exp_empty = '0;
      for (int k = 0; k < 3; k++) begin
         if (q[k].size() != 0) exp_data[k*32 +: 32] = q[k][0];
         exp_empty[k] = (q[k].size() == 0);
      end
      exp_ready = (mphase == 0) && ((wl >= 2'd3) || (q[wl].size() < 4));
      if (do_chk) begin
         chk("rd_data",    rd_data,    exp_data);
         chk("lane_empty", {93'd0, lane_empty}, {93'd0, exp_empty});
         chk("wr_ready",   {95'd0, wr_ready},   {95'd0, exp_ready});
         chk("busy",       {95'd0, busy},       {95'd0, mphase != 0});
         chk("finished",   {95'd0, finished},   {95'd0, mphase == 2});
         chk("err",        {94'd0, err},        {94'd0, merr});
      end
      if (r) begin
         for (int k = 0; k < 3; k++) q[k].delete();
         mphase = 0;
         merr   = 2'b00;
      end else if (mphase == 0) begin
         if (wv && exp_ready) begin
            if (wl < 2'd3) q[wl].push_back(wd);
            else merr[1] = 1'b1;
         end
         if (cm) mphase = 1;
      end else if (mphase == 1) begin
         for (int k = 0; k < 3; k++) begin
            if (re[k]) begin
               if (q[k].size() == 0) merr[0] = 1'b1;
               else void'(q[k].pop_front());
            end
         end
         all_empty = 1'b1;
         for (int k = 0; k < 3; k++) if (q[k].size() != 0) all_empty = 1'b0;
         if (all_empty) mphase = 2;
      end else begin
         mphase = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] pat [5];
      mphase = 0;
      merr   = 2'b00;
      rst = 1'b1; wr_valid = 1'b0; wr_lane = '0; wr_data = '0; commit = 1'b0; rd_en = '0;
      @(posedge clk);
      #1;
      cyc(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 3'b000, 1'b0);
      cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 3'b000);

      // Skewed three-lane stream
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < 3; j++)
            cyc(1'b0, 1'b1, 2'(k), 32'(3 * k + j + 1), 1'b0, 3'b000);
      cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 3'b000);
      pat[0] = 3'b001; pat[1] = 3'b011; pat[2] = 3'b111; pat[3] = 3'b110; pat[4] = 3'b100;
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, pat[i]);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 3'b000);

      // Full lane back-pressure, then underflow on an empty lane
      for (int j = 0; j < 5; j++) cyc(1'b0, 1'b1, 2'd1, 32'hA0 + 32'(j), 1'b0, 3'b000);
      cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 3'b000);
      cyc(1'b0, 1'b1, 2'd1, 32'hBAD, 1'b1, 3'b000);
      cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 3'b001);
      for (int j = 0; j < 6; j++) cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 3'b010);

      // Out-of-range lane write
      cyc(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 3'b000);
      cyc(1'b0, 1'b1, 2'd3, 32'h55, 1'b0, 3'b000);
      cyc(1'b0, 1'b0, 2'd3, 32'd0, 1'b0, 3'b000);

      // Commit with nothing queued
      cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 3'b000);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 3'b000);

      // Reset mid-stream with entries still queued
      cyc(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 3'b000);
      for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, 2'd2, 32'hC0 + 32'(j), 1'b0, 3'b000);
      cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 3'b000);
      cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 3'b100);
      cyc(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 3'b000);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 3'b100);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
             2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 11) == 0),
             3'($urandom_range(0, 7)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
